fifo_rd_stream: RTL and testbench
=================================

# fifo_rd_stream

Read-side adapter that sits directly downstream of the synchronous BRAM FIFO. It drains the FIFO through its RD/EMPTY/DATA_RD port, which has 1-cycle read latency, and presents the words as a valid/ready stream with a 3-entry output buffer, so back-pressure never stalls or loses an in-flight read. It also frames the stream into fixed-length packets by asserting M_LAST on every PKT_LEN-th beat.

## Interface
- length, 16, data word width; must match the FIFO's word width.
- PKT_LEN, 8, beats per packet; legal range 1..65535.
- CLK  in  1  single clock, rising edge; shared with the FIFO.
- RESETN  in  1  reset, synchronous, active-low.
- FIFO_EMPTY  in  1  FIFO EMPTY flag; registered inside the FIFO.
- FIFO_RD  out  1  read request to FIFO RD.
- FIFO_DATA  in  length  FIFO DATA_RD; valid exactly 1 cycle after an accepted read.
- M_DATA  out  length  stream data, taken from the head of the output buffer.
- M_VALID  out  1  output buffer non-empty.
- M_READY  in  1  downstream accept.
- M_LAST  out  1  high with the final beat of each packet.

## Operation
- State:
  - occ: buffer occupancy, 0..3.
  - inflight: 1 bit; a read was issued last cycle.
  - 3-entry circular buffer with head and tail pointers, mod 3.
  - beat_cnt: 16 bit, 0..PKT_LEN-1.
- Read issue rule: FIFO_RD = !FIFO_EMPTY && (occ + inflight < 3).
  - FIFO_RD is combinational from FIFO_EMPTY and registered state only. It never depends on M_READY.
  - The rule guarantees a buffer slot for every in-flight word.
- Capture: when inflight=1, FIFO_DATA is written at the tail on the following edge, and tail advances by 1 mod 3.
- inflight <= FIFO_RD on every edge.
- Pop: a handshake occurs when M_VALID && M_READY. Head advances by 1 mod 3.
- Occupancy update: occ <= occ + capture - pop. A simultaneous capture and pop leaves occ unchanged.
  - A capture and a pop on the same entry cannot occur. A word is captured one edge before it is visible at the head.
- M_VALID = (occ != 0). M_DATA = buf[head], combinational from registers.
- Framing:
  - On each handshake, beat_cnt increments. It wraps to 0 on the handshake where beat_cnt == PKT_LEN-1.
  - M_LAST = M_VALID && (beat_cnt == PKT_LEN-1). With PKT_LEN=1, M_LAST = M_VALID.
- Ordering: words leave in exactly the order they were read from the FIFO. None are dropped and none are duplicated.
- M_DATA while M_VALID=0 is don't-care. Verification must not check it.
- Stream rule: once M_VALID=1, M_VALID and M_DATA hold stable until the handshake.
- Reset (RESETN=0 at an edge):
  - occ, inflight, head, tail and beat_cnt clear to 0, and buffer contents are not cleared.
  - Outputs then read FIFO_RD=0 only while FIFO_EMPTY=1 (the FIFO also resets to EMPTY), M_VALID=0, M_LAST=0.
  - A mid-operation reset discards an in-flight read. FIFO_DATA on the cycle after reset is ignored.
  - A mid-operation reset also discards buffered words and any partial packet.

## Timing
- Cycle t: FIFO_RD=1 with FIFO_EMPTY=0. Cycle t+1: FIFO_DATA is valid and captured at the end of t+1. Cycle t+2: M_VALID=1 with that word.
  - Latency from read issue to M_VALID is 2 cycles.
- Throughput: with M_READY held at 1 and the FIFO non-empty, steady state is occ=1 and inflight=1, so one beat is delivered per cycle.
- Back-pressure:
  - With M_READY=0, reads stop once occ + inflight = 3.
  - At most 3 words are held. Reads resume in the cycle after the first pop.
- FIFO draining: when the FIFO goes EMPTY, FIFO_RD drops in the same cycle. Already-issued words still arrive and are delivered.
- No combinational path exists from M_READY to FIFO_RD, M_VALID or M_DATA.

## Test plan
- Reset: hold RESETN=0 for 3 cycles with FIFO empty -> FIFO_RD=0, M_VALID=0, M_LAST=0 throughout. After release, outputs are unchanged until the FIFO holds data.
- Single word: FIFO loaded with 0x00A5, M_READY=1 -> FIFO_RD pulses for 1 cycle, M_VALID=1 exactly 2 cycles later with M_DATA=0x00A5, then M_VALID=0.
- Streaming: 20 words 0x0001..0x0014 written, M_READY=1, PKT_LEN=8 ->
  - 20 consecutive beats with M_VALID high, in order.
  - M_LAST on 0x0008 and 0x0010; beat_cnt=4 at the end.
- Back-pressure: 10 words buffered in the FIFO, M_READY=0 for 10 cycles ->
  - Exactly 3 FIFO_RD pulses, then FIFO_RD=0 while M_VALID=1 and M_DATA=0x0001 are held stable.
  - On M_READY=1, all 10 words are delivered in order.
- Random: M_READY toggled pseudo-randomly, 500 words written at random times ->
  - Scoreboard shows no loss, duplication or reordering.
  - occ never exceeds 3 and FIFO_RD is never high while FIFO_EMPTY=1.
- Reset mid-stream: RESETN=0 for 1 cycle while inflight=1, occ=2 and the packet is at beat 5 ->
  - Next cycle M_VALID=0 and the in-flight word is dropped.
  - After refill, M_LAST falls on the 8th post-reset beat.

Source files
------------

// File: rtl/fifo_rd_stream_if.sv
// FIFO read-port and valid/ready stream signals shared by fifo_rd_stream and its environment.
// The master side is the adapter; the slave side is the FIFO plus the downstream sink.
interface fifo_rd_stream_if #(parameter int length = 16);
  logic              FIFO_EMPTY;
  logic              FIFO_RD;
  logic [length-1:0] FIFO_DATA;
  logic [length-1:0] M_DATA;
  logic              M_VALID;
  logic              M_READY;
  logic              M_LAST;

  modport master (
    input  FIFO_EMPTY, FIFO_DATA, M_READY,
    output FIFO_RD, M_DATA, M_VALID, M_LAST
  );

  modport slave (
    output FIFO_EMPTY, FIFO_DATA, M_READY,
    input  FIFO_RD, M_DATA, M_VALID, M_LAST
  );
endinterface

// File: rtl/fifo_rd_stream.sv
// Drains a 1-cycle-latency FIFO read port into a 3-entry skid buffer and presents it as a
// valid/ready stream, marking every PKT_LEN-th beat with M_LAST.
module fifo_rd_stream #(
  parameter int length  = 16,
  parameter int PKT_LEN = 8
) (
  input logic              CLK,
  input logic              RESETN,
  fifo_rd_stream_if.master bus
);
  localparam logic [15:0] LAST_BEAT = 16'(PKT_LEN - 1);

  logic [1:0]        occ_q, occ_d;
  logic              inflight_q;
  logic [1:0]        head_q, head_d;
  logic [1:0]        tail_q, tail_d;
  logic [15:0]       beat_q, beat_d;
  logic [length-1:0] mem_q [3];

  logic rd, pop, vld;

  function automatic logic [1:0] inc3(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Issue only when a slot is reserved for the word; M_READY never feeds this.
  assign rd  = !bus.FIFO_EMPTY && (({1'b0, occ_q} + {2'b00, inflight_q}) < 3'd3);
  assign vld = (occ_q != 2'd0);
  assign pop = vld && bus.M_READY;

  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    beat_d = beat_q;
    case ({inflight_q, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
    if (inflight_q) tail_d = inc3(tail_q);
    if (pop) begin
      head_d = inc3(head_q);
      beat_d = (beat_q == LAST_BEAT) ? 16'd0 : beat_q + 16'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      head_q     <= 2'd0;
      tail_q     <= 2'd0;
      beat_q     <= 16'd0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= rd;
      head_q     <= head_d;
      tail_q     <= tail_d;
      beat_q     <= beat_d;
    end
  end

  // Storage is never reset; occupancy alone decides which entries are live.
  always_ff @(posedge CLK) begin
    if (inflight_q) mem_q[tail_q] <= bus.FIFO_DATA;
  end

  assign bus.FIFO_RD = rd;
  assign bus.M_VALID = vld;
  assign bus.M_DATA  = mem_q[head_q];
  assign bus.M_LAST  = vld && (beat_q == LAST_BEAT);
endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream: a behavioural registered-EMPTY FIFO feeds the DUT and a
// negedge monitor collects handshakes and watches stream/issue invariants.
module tb_fifo_rd_stream;
  localparam int W = 16;

  logic CLK = 1'b0;
  logic RESETN = 1'b0;
  always #5 CLK = ~CLK;

  fifo_rd_stream_if #(.length(W)) bus ();
  fifo_rd_stream #(.length(W), .PKT_LEN(8)) dut (.CLK(CLK), .RESETN(RESETN), .bus(bus));

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Behavioural FIFO: 1-cycle read latency, EMPTY registered, cleared by the same reset.
  logic         wr_en = 1'b0;
  logic [W-1:0] wr_data = '0;
  logic         f_empty = 1'b1;
  logic [W-1:0] f_data = '0;
  logic [W-1:0] fq[$];

  assign bus.FIFO_EMPTY = f_empty;
  assign bus.FIFO_DATA  = f_data;
  initial bus.M_READY = 1'b0;

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (!RESETN) begin
      fq.delete();
      f_empty <= 1'b1;
    end else begin
      if (bus.FIFO_RD && !f_empty) f_data <= fq.pop_front();
      if (wr_en) fq.push_back(wr_data);
      f_empty <= (fq.size() == 0);
    end
  end

  // Monitor: values sampled mid-cycle are the ones the next rising edge acts on.
  logic [W-1:0] rx_q[$];
  logic         last_q[$];
  int           cyc_q[$];
  int           issued = 0, popped = 0;
  logic         pend = 1'b0;
  logic [W-1:0] pend_data = '0;

  always @(negedge CLK) begin
    if (!RESETN) begin
      issued = 0;
      popped = 0;
      pend   = 1'b0;
    end else begin
      checks++;
      if (bus.FIFO_RD === 1'b1 && bus.FIFO_EMPTY === 1'b1) begin
        errors++;
        $display("FAIL rd_while_empty t=%0t got FIFO_RD=1 exp 0", $time);
      end
      checks++;
      if (issued - popped > 3) begin
        errors++;
        $display("FAIL held_words t=%0t got %0d exp <=3", $time, issued - popped);
      end
      if (pend) begin
        checks++;
        if (bus.M_VALID !== 1'b1 || bus.M_DATA !== pend_data) begin
          errors++;
          $display("FAIL stream_hold t=%0t got v=%b d=%h exp v=1 d=%h", $time,
                   bus.M_VALID, bus.M_DATA, pend_data);
        end
      end
      if (bus.FIFO_RD === 1'b1) issued++;
      if (bus.M_VALID === 1'b1 && bus.M_READY === 1'b1) begin
        rx_q.push_back(bus.M_DATA);
        last_q.push_back(bus.M_LAST);
        cyc_q.push_back(cyc);
        popped++;
      end
      pend      = (bus.M_VALID === 1'b1) && (bus.M_READY !== 1'b1);
      pend_data = bus.M_DATA;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESETN = 1'b0;
    wr_en = 1'b0;
    tick();
    RESETN = 1'b1;
    rx_q.delete();
    last_q.delete();
    cyc_q.delete();
  endtask

  task automatic write_words(input logic [W-1:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      wr_en = 1'b1;
      wr_data = first + W'(i);
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic wait_rx(input int n, input int budget, input string name);
    int c = 0;
    while (rx_q.size() < n && c < budget) begin
      tick();
      c++;
    end
    checks++;
    if (rx_q.size() < n) begin
      errors++;
      $display("FAIL %s_timeout got %0d beats exp %0d", name, rx_q.size(), n);
    end
  endtask

  task automatic test_reset();
    RESETN = 1'b0;
    bus.M_READY = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      if (i == 2) RESETN = 1'b1;
      @(negedge CLK);
      checks++;
      if (bus.FIFO_RD !== 1'b0 || bus.M_VALID !== 1'b0 || bus.M_LAST !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs cyc%0d got rd=%b v=%b l=%b exp 0 0 0", i,
                 bus.FIFO_RD, bus.M_VALID, bus.M_LAST);
      end
      tick();
    end
  endtask

  task automatic test_single();
    logic exp_rd[4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic exp_v[4]  = '{1'b0, 1'b0, 1'b1, 1'b0};
    do_reset();
    bus.M_READY = 1'b1;
    write_words(16'h00A5, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      checks++;
      if (bus.FIFO_RD !== exp_rd[i] || bus.M_VALID !== exp_v[i]) begin
        errors++;
        $display("FAIL single_cyc%0d got rd=%b v=%b exp rd=%b v=%b", i,
                 bus.FIFO_RD, bus.M_VALID, exp_rd[i], exp_v[i]);
      end
      if (exp_v[i]) begin
        checks++;
        if (bus.M_DATA !== 16'h00A5 || bus.M_LAST !== 1'b0) begin
          errors++;
          $display("FAIL single_data got d=%h l=%b exp d=00a5 l=0", bus.M_DATA, bus.M_LAST);
        end
      end
      tick();
    end
  endtask

  task automatic test_stream();
    do_reset();
    bus.M_READY = 1'b1;
    write_words(16'h0001, 20);
    wait_rx(20, 60, "stream");
    for (int i = 0; i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== W'(i + 1) || last_q[i] !== (i == 7 || i == 15) ||
          cyc_q[i] !== cyc_q[0] + i) begin
        errors++;
        $display("FAIL stream_beat%0d got d=%h l=%b dc=%0d exp d=%h l=%b dc=%0d", i, rx_q[i],
                 last_q[i], cyc_q[i] - cyc_q[0], W'(i + 1), (i == 7 || i == 15), i);
      end
    end
    checks++;
    if (dut.beat_q !== 16'd4) begin
      errors++;
      $display("FAIL stream_beat_cnt got %0d exp 4", dut.beat_q);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.M_READY = 1'b0;
    write_words(16'h0001, 10);
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      checks++;
      if (bus.FIFO_RD !== 1'b0 || bus.M_VALID !== 1'b1 || bus.M_DATA !== 16'h0001) begin
        errors++;
        $display("FAIL bp_hold cyc%0d got rd=%b v=%b d=%h exp rd=0 v=1 d=0001", i,
                 bus.FIFO_RD, bus.M_VALID, bus.M_DATA);
      end
      tick();
    end
    checks++;
    if (issued !== 3) begin
      errors++;
      $display("FAIL bp_reads got %0d exp 3", issued);
    end
    bus.M_READY = 1'b1;
    wait_rx(10, 60, "bp");
    for (int i = 0; i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== W'(i + 1) || last_q[i] !== (i == 7)) begin
        errors++;
        $display("FAIL bp_beat%0d got d=%h l=%b exp d=%h l=%b", i, rx_q[i], last_q[i],
                 W'(i + 1), (i == 7));
      end
    end
  endtask

  task automatic test_random();
    int wr_n = 0;
    int c = 0;
    do_reset();
    while (!(wr_n == 500 && rx_q.size() == 500) && c < 8000) begin
      wr_en = (wr_n < 500) && ($urandom_range(0, 1) == 1);
      wr_data = W'(32'h8000 + wr_n);
      bus.M_READY = ($urandom_range(0, 2) != 0);
      if (wr_en) wr_n++;
      tick();
      c++;
    end
    wr_en = 1'b0;
    bus.M_READY = 1'b1;
    checks++;
    if (rx_q.size() != 500) begin
      errors++;
      $display("FAIL random_count got %0d exp 500", rx_q.size());
    end
    for (int i = 0; i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== W'(32'h8000 + i) || last_q[i] !== (i % 8 == 7)) begin
        errors++;
        $display("FAIL random_beat%0d got d=%h l=%b exp d=%h l=%b", i, rx_q[i], last_q[i],
                 W'(32'h8000 + i), (i % 8 == 7));
      end
    end
  endtask

  task automatic test_mid_reset();
    int c = 0;
    do_reset();
    bus.M_READY = 1'b0;
    write_words(16'h0021, 10);
    bus.M_READY = 1'b1;
    while (rx_q.size() < 5 && c < 40) begin
      tick();
      c++;
    end
    bus.M_READY = 1'b0;
    tick();
    checks++;
    if (dut.occ_q !== 2'd2 || dut.inflight_q !== 1'b1 || dut.beat_q !== 16'd5) begin
      errors++;
      $display("FAIL midrst_setup got occ=%0d inf=%b beat=%0d exp occ=2 inf=1 beat=5",
               dut.occ_q, dut.inflight_q, dut.beat_q);
    end
    do_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      checks++;
      if (bus.M_VALID !== 1'b0 || bus.FIFO_RD !== 1'b0) begin
        errors++;
        $display("FAIL midrst_idle cyc%0d got v=%b rd=%b exp v=0 rd=0", i,
                 bus.M_VALID, bus.FIFO_RD);
      end
      tick();
    end
    bus.M_READY = 1'b1;
    write_words(16'h0100, 8);
    wait_rx(8, 40, "midrst");
    for (int i = 0; i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== W'(16'h0100 + i) || last_q[i] !== (i == 7)) begin
        errors++;
        $display("FAIL midrst_beat%0d got d=%h l=%b exp d=%h l=%b", i, rx_q[i], last_q[i],
                 W'(16'h0100 + i), (i == 7));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_random();
    test_mid_reset();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
